// File: rtl/an_code_pkg.sv
// Shared AN-code constants and FSM state type.
// Used by the sequential encoder and by the downstream AN-code LUT decoder,
// so A, N_W and W_W have a single source of truth.
//   A   : AN-code multiplier (odd)
//   N_W : data word width
//   A_W : bit width of A, sets the encoder iteration count
//   W_W : codeword width, N_W + A_W
package an_code_pkg;

  localparam int unsigned A   = 17619;
  localparam int unsigned N_W = 28;
  localparam int unsigned A_W = 15;
  localparam int unsigned W_W = N_W + A_W;

  // A as an A_W-bit vector, loaded into the multiplier shift register
  localparam logic [A_W-1:0] A_VEC = A_W'(A);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } an_state_t;

endpackage

// File: rtl/an_shift_add_step.sv
// One shift-and-add iteration of the AN-code multiplier.
// Purely combinational; kept in its own module so the W_W-bit adder is a
// distinct timing path.
// Ports:
//   acc      in   W_W  current accumulator
//   mcand    in   W_W  current (already shifted) multiplicand
//   mbit     in   1    current LSB of the multiplier shift register
//   acc_next out  W_W  acc + mcand when mbit is set, else acc
module an_shift_add_step
  import an_code_pkg::*;
(
  input  logic [W_W-1:0] acc,
  input  logic [W_W-1:0] mcand,
  input  logic           mbit,
  output logic [W_W-1:0] acc_next
);

  // Unsigned W_W-bit add; any carry out of the MSB is dropped (cannot occur
  // for in-range data since A*(2^N_W-1) < 2^W_W).
  assign acc_next = mbit ? (acc + mcand) : acc;

endmodule

// File: rtl/an_seq_encoder28.sv
// Sequential AN-code encoder: W = A * N using one shift-and-add step per
// clock over the A_W bits of A. Ready/valid on input and output.
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    in_n is valid
//   in_ready   out  1    encoder can accept a word (IDLE only)
//   in_n       in   N_W  data word, sampled only at the accept edge
//   out_valid  out  1    out_w holds a finished codeword (DONE)
//   out_ready  in   1    downstream takes out_w
//   out_w      out  W_W  codeword A*N, held at its last value outside DONE
//   busy       out  1    high in MUL and DONE
module an_seq_encoder28
  import an_code_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] in_n,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W_W-1:0] out_w,
  output logic           busy
);

  localparam logic [3:0] CNT_LAST = 4'(A_W - 1);

  an_state_t      state;
  logic [W_W-1:0] acc;
  logic [W_W-1:0] mcand;
  logic [A_W-1:0] mplier;
  logic [3:0]     cnt;
  logic [W_W-1:0] acc_next;

  an_shift_add_step u_step (
    .acc      (acc),
    .mcand    (mcand),
    .mbit     (mplier[0]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      out_w     <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= {{(W_W-N_W){1'b0}}, in_n};
            mplier   <= A_VEC;
            acc      <= '0;
            cnt      <= '0;
            state    <= MUL;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == CNT_LAST) begin
            // Final iteration: publish the completed product directly so
            // out_w never shows a partial sum.
            state     <= DONE;
            out_valid <= 1'b1;
            out_w     <= acc_next;
          end
        end
        DONE: begin
          // No pass-through: the handoff edge returns to IDLE only, so a
          // coincident in_valid is taken on the following edge.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_an_seq_encoder28.sv
module tb_an_seq_encoder28;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] in_n;
  logic        out_valid;
  logic        out_ready;
  logic [42:0] out_w;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  an_seq_encoder28 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; sample/drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Present n, check latency, codeword, divisibility, and handoff.
  task automatic run_word(input logic [27:0] n, input logic [63:0] exp, input string tag);
    logic [63:0] w;
    int          waited;
    waited = 0;
    while (!in_ready && waited < 40) begin
      step();
      waited++;
    end
    chk({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    in_n     = n;
    step();                       // accept edge
    in_valid = 1'b0;
    in_n     = ~n;                // must not affect the result
    chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
    for (int i = 0; i < 14; i++) step();
    chk({tag, "_not_yet_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy_mul"}, 64'(busy), 64'd1);
    step();                       // accept + 15 edges: DONE
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_out_w"}, 64'(out_w), exp);
    w = 64'(out_w);
    chk({tag, "_mod_A"}, w % 64'd17619, 64'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_handoff_idle"}, 64'(in_ready), 64'd1);
    chk({tag, "_handoff_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [42:0] held_w;
    logic [27:0] rn;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_n      = '0;
    out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_w", 64'(out_w), 64'd0);

    // Basic and range edges
    run_word(28'd1, 64'd17619, "n1");
    run_word(28'd0, 64'd0, "n0");
    run_word(28'd12345, 64'd217506555, "n12345");
    run_word(28'hFFFFFFF, 64'd4729564281645, "nmax");

    // Backpressure: 20 cycles in DONE with out_ready low
    in_valid = 1'b1;
    in_n     = 28'd7;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_w", 64'(out_w), 64'd123333);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_w", 64'(out_w), 64'd123333);
      chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    chk("bp_release_valid", 64'(out_valid), 64'd0);
    chk("bp_w_held_idle", 64'(out_w), 64'd123333);

    // Busy input: in_valid pulse with 5 during MUL of 3 is ignored
    in_valid = 1'b1;
    in_n     = 28'd3;
    step();
    in_valid = 1'b0;
    step();
    step();
    in_valid = 1'b1;
    in_n     = 28'd5;
    step();
    in_valid = 1'b0;
    chk("busy_in_ready", 64'(in_ready), 64'd0);
    for (int i = 0; i < 12; i++) step();
    chk("busy_done", 64'(out_valid), 64'd1);
    chk("busy_w3", 64'(out_w), 64'd52857);
    // in_valid coincides with the handoff edge: must not be accepted there
    in_valid  = 1'b1;
    in_n      = 28'd5;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("nopass_in_ready", 64'(in_ready), 64'd1);
    chk("nopass_busy", 64'(busy), 64'd0);
    run_word(28'd5, 64'd88095, "n5_after");
    held_w = out_w;
    chk("held_after_handoff", 64'(held_w), 64'd88095);

    // Reset mid-MUL
    in_valid = 1'b1;
    in_n     = 28'd9;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_w", 64'(out_w), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    for (int i = 0; i < 20; i++) step();
    chk("midrst_no_partial", 64'(out_valid), 64'd0);
    run_word(28'd2, 64'd35238, "n2_after_rst");

    // A few random words against the product model
    for (int k = 0; k < 6; k++) begin
      rn = 28'($urandom);
      run_word(rn, 64'(rn) * 64'd17619, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
